// File: rtl/pim_pkg.sv
// pim_pkg: opcode and FSM types plus the accumulate adder shared by the PIM controller; PIM_ACC_SAT_EN selects saturating accumulate.
package pim_pkg;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_ACC, OP_RSVD} op_t;
  typedef enum logic [1:0] {IDLE, EXEC, WB, RESP} state_t;
  function automatic logic [31:0] acc_add(input logic [31:0] a, input logic [31:0] b, input int w);
    logic [31:0] mask;
`ifdef PIM_ACC_SAT_EN
    logic [32:0] s;
    mask = (w >= 32) ? '1 : (32'd1 << w) - 32'd1;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, mask}) ? mask : s[31:0];
`else
    mask = (w >= 32) ? '1 : (32'd1 << w) - 32'd1;
    return (a + b) & mask;
`endif
  endfunction
endpackage

// File: rtl/pim_mem_ctrl_rr_arbiter.sv
// rr_arbiter: round-robin grant among NUM_CH requesters, pointer advances past each grant.
module rr_arbiter #(
  parameter int NUM_CH = 4,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              en,
  output logic [NUM_CH-1:0] gnt,
  output logic [CH_W-1:0]   idx
);
  logic [CH_W-1:0] ptr;
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (en && gnt == '0 && req[(int'(ptr) + k) % NUM_CH]) begin
        gnt[(int'(ptr) + k) % NUM_CH] = 1'b1;
        idx = CH_W'((int'(ptr) + k) % NUM_CH);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (|gnt) ptr <= (idx == CH_W'(NUM_CH - 1)) ? '0 : idx + 1'b1;
  end
endmodule

// File: rtl/pim_mem_ctrl.sv
// pim_mem_ctrl: multi-channel read/write/accumulate front end for a PIM word array; PIM_ACC_SAT_EN makes ACC saturate.
module pim_mem_ctrl
  import pim_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH = 4,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            req_valid,
  output logic [NUM_CH-1:0]            req_ready,
  input  logic [2*NUM_CH-1:0]          req_op,
  input  logic [ADDR_WIDTH*NUM_CH-1:0] req_addr,
  input  logic [DATA_WIDTH*NUM_CH-1:0] req_data,
  output logic                         rsp_valid,
  output logic [CH_W-1:0]              rsp_ch,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic                         rsp_err
);
  state_t state, state_n;
  op_t cur_op;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_data, rd, res, sum;
  logic [CH_W-1:0] cur_ch, gnt_idx;
  logic [NUM_CH-1:0] gnt;
  logic mem_we;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk(clk),
    .rst(rst),
    .req(req_valid),
    .en(state == IDLE && !rst),
    .gnt(gnt),
    .idx(gnt_idx)
  );

  assign req_ready = gnt;
  assign sum = DATA_WIDTH'(acc_add(32'(rd), 32'(cur_data), DATA_WIDTH));
  assign mem_we = (state == EXEC && cur_op == OP_WRITE) || state == WB;

  always_comb begin
    state_n = (state == IDLE) ? ((|gnt) ? EXEC : IDLE) :
              (state == EXEC) ? ((cur_op == OP_ACC) ? WB : RESP) :
              (state == WB)   ? RESP : IDLE;
  end

  // Single-port array: one address per cycle, contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[cur_addr] <= (state == WB) ? sum : cur_data;
    if (state == EXEC) rd <= mem[cur_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cur_op <= OP_READ;
      cur_addr <= '0;
      cur_data <= '0;
      cur_ch <= '0;
      res <= '0;
    end else begin
      state <= state_n;
      if (|gnt) begin
        cur_op <= op_t'(req_op[int'(gnt_idx)*2 +: 2]);
        cur_addr <= req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
        cur_data <= req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        cur_ch <= gnt_idx;
      end
      if (state == EXEC) res <= (cur_op == OP_WRITE) ? cur_data : '0;
      if (state == WB) res <= sum;
    end
  end

  // Response fields are decoded from registers only and held at zero outside RESP.
  assign rsp_valid = state == RESP;
  assign rsp_ch = rsp_valid ? cur_ch : '0;
  assign rsp_err = rsp_valid && cur_op == OP_RSVD;
  assign rsp_data = !rsp_valid ? '0 : (cur_op == OP_READ) ? rd : res;
endmodule

// File: tb/tb_pim_mem_ctrl.sv
// tb_pim_mem_ctrl: scoreboard bench for pim_mem_ctrl with a behavioural memory/round-robin model.
module tb_pim_mem_ctrl;
  localparam int AW = 10, DW = 16, NC = 4, CW = 2;
  logic clk = 0, rst = 1;
  logic [NC-1:0] req_valid = '0, req_ready;
  logic [2*NC-1:0] req_op = '0;
  logic [AW*NC-1:0] req_addr = '0;
  logic [DW*NC-1:0] req_data = '0;
  logic rsp_valid, rsp_err;
  logic [CW-1:0] rsp_ch;
  logic [DW-1:0] rsp_data;

  pim_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ch(rsp_ch),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    logic [DW-1:0] data;
    logic err;
    bit dc;
    int due;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  int glog[$];
  logic [DW-1:0] mm[1<<AW];
  bit known[1<<AW];
  bit pv[NC];
  logic [1:0] pop[NC];
  logic [AW-1:0] pa[NC];
  logic [DW-1:0] pd[NC];
  int cyc = 0, busy_until = 0, mptr = 0, last_addr = 0, checks = 0, errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] ref_acc(logic [DW-1:0] a, logic [DW-1:0] b);
    int s = int'(a) + int'(b);
`ifdef PIM_ACC_SAT_EN
    return (s >= (1 << DW)) ? DW'((1 << DW) - 1) : DW'(s);
`else
    return DW'(s % (1 << DW));
`endif
  endfunction

  task automatic accept(int ch);
    exp_t x;
    int a = int'(pa[ch]);
    x.ch = ch; x.err = 0; x.dc = 0; x.data = '0;
    case (pop[ch])
      2'b00: begin x.data = mm[a]; x.dc = !known[a]; end
      2'b01: begin mm[a] = pd[ch]; known[a] = 1; x.data = pd[ch]; end
      2'b10: begin x.data = ref_acc(mm[a], pd[ch]); x.dc = !known[a]; mm[a] = x.data; end
      default: x.err = 1;
    endcase
    x.due = cyc + ((pop[ch] == 2'b10) ? 3 : 2);
    busy_until = cyc + ((pop[ch] == 2'b10) ? 4 : 3);
    sb.push_back(x);
    glog.push_back(ch);
    mptr = (ch + 1) % NC;
    pv[ch] = 0;
    last_addr = a;
  endtask

  task automatic step();
    logic [NC-1:0] exp_g;
    int g;
    @(negedge clk);
    for (int c = 0; c < NC; c++) begin
      req_valid[c] = pv[c];
      req_op[2*c +: 2] = pop[c];
      req_addr[c*AW +: AW] = pa[c];
      req_data[c*DW +: DW] = pd[c];
    end
    #1;
    exp_g = '0;
    g = -1;
    if (cyc >= busy_until)
      for (int k = 0; k < NC; k++)
        if (g < 0 && pv[(mptr + k) % NC]) g = (mptr + k) % NC;
    if (g >= 0) exp_g[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_g));
    for (int c = 0; c < NC; c++)
      if (req_valid[c] && req_ready[c]) accept(c);
  endtask

  task automatic pend(int ch, logic [1:0] op, logic [AW-1:0] a, logic [DW-1:0] d);
    pv[ch] = 1; pop[ch] = op; pa[ch] = a; pd[ch] = d;
  endtask

  task automatic issue(int ch, logic [1:0] op, logic [AW-1:0] a, logic [DW-1:0] d);
    pend(ch, op, a, d);
    for (int i = 0; i < 50 && pv[ch]; i++) step();
    if (pv[ch]) begin
      chk("accept_timeout", 32'(pv[ch]), 0);
      pv[ch] = 0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && sb.size() > 0; i++) step();
    chk("drain", sb.size(), 0);
  endtask

  task automatic pulse_reset(bit drop_inflight);
    @(negedge clk);
    rst = 1;
    sb.delete();
    if (drop_inflight) known[last_addr] = 0;
    mptr = 0;
    busy_until = 0;
    #1 chk("ready_in_reset", 32'(req_ready), 0);
    @(posedge clk);
    #1 rst = 0;
  endtask

  function automatic bit any_pending();
    for (int c = 0; c < NC; c++) if (pv[c]) return 1;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (rst) chk("rsp_valid_in_reset", 32'(rsp_valid), 0);
    else begin
      if (sb.size() > 0 && cyc > sb[0].due) begin
        chk("rsp_late", cyc, sb[0].due);
        void'(sb.pop_front());
      end
      if (rsp_valid) begin
        if (sb.size() == 0) chk("rsp_unexpected_ch", 32'(rsp_ch), 32'hFFFF_FFFF);
        else begin
          e = sb.pop_front();
          chk("rsp_cycle", cyc, e.due);
          chk("rsp_ch", 32'(rsp_ch), 32'(e.ch));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          if (!e.dc) chk("rsp_data", 32'(rsp_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    int seq[5];
    for (int c = 0; c < NC; c++) begin pv[c] = 0; pop[c] = 0; pa[c] = 0; pd[c] = 0; end
    repeat (3) @(posedge clk);
    #1 rst = 0;
    issue(1, 2'b01, 10'h3FF, 16'hBEEF);
    issue(1, 2'b00, 10'h3FF, 16'h0000);
    drain();
    issue(0, 2'b01, 10'd5, 16'hFFF0);
    issue(0, 2'b10, 10'd5, 16'h0020);
    issue(0, 2'b00, 10'd5, 16'h0000);
    drain();
    issue(2, 2'b01, 10'd7, 16'h1234);
    issue(2, 2'b11, 10'd7, 16'h5555);
    issue(2, 2'b00, 10'd7, 16'h0000);
    drain();
    pulse_reset(0);
    glog.delete();
    for (int i = 0; i < 40 && glog.size() < 5; i++) begin
      for (int c = 0; c < NC; c++) if (!pv[c]) pend(c, 2'b00, 10'h3FF, 16'h0);
      step();
    end
    for (int c = 0; c < NC; c++) pv[c] = 0;
    seq = '{0, 1, 2, 3, 0};
    chk("fair_count", glog.size(), 5);
    for (int i = 0; i < 5 && i < glog.size(); i++) chk($sformatf("fair_grant%0d", i), glog[i], seq[i]);
    drain();
    foreach (seq[i]) if (i < 2) begin
      int ch = (i == 0) ? 3 : 1;
      issue(ch, 2'b10, 10'd9, 16'h0001);
      step();
      pulse_reset(1);
      pend(0, 2'b00, 10'h3FF, 16'h0);
      pend(3, 2'b00, 10'd7, 16'h0);
      step();
      chk("post_reset_grant", glog[$], 0);
      for (int k = 0; k < 20 && pv[3]; k++) step();
      chk("post_reset_ch3_done", 32'(pv[3]), 0);
      pv[3] = 0;
      drain();
    end
    for (int i = 0; i < 250; i++) begin
      for (int c = 0; c < NC; c++)
        if (!pv[c] && $urandom_range(0, 2) == 0)
          pend(c, 2'($urandom_range(0, 3)), AW'($urandom_range(0, 15)), DW'($urandom));
      step();
    end
    for (int i = 0; i < 300 && any_pending(); i++) step();
    chk("random_all_accepted", 32'(any_pending()), 0);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
